// File: rtl/fpadd_pkg.sv
// Shared types and constants for the serial FP adder scheduler.
package fpadd_pkg;

    typedef enum logic [1:0] {S_WAIT, S_OPA, S_OPB} fpsched_state_t;

    localparam int FP_W = 32;
    localparam logic [31:0] FP_POS_ZERO = '0;

endpackage

// File: rtl/fpadd_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr.
module fpadd_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    int idx;

    // Scan from the farthest offset back to ptr so the closest request wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign gnt_onehot[gi] = gnt_any && (gnt_idx == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one serial FP adder between NREQ requesters.
// The adder cycles continuously; rounds with no request carry a 0+0 dummy op.
module fpadd_sched
    import fpadd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [FP_W-1:0]      rsp_sum,
    input  logic                 fpa_ready,
    input  logic [FP_W-1:0]      fpa_sum,
    output logic [FP_W-1:0]      fpa_a,
    output logic                 busy,
    output logic                 proto_err
);

    fpsched_state_t  state_reg, state_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic            inflight_reg, inflight_next;
    logic [FP_W-1:0] opa_reg, opa_next;
    logic [FP_W-1:0] opb_reg, opb_next;
    logic [IDW-1:0]  cur_id_reg, cur_id_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic [IDW-1:0]  rsp_id_reg, rsp_id_next;
    logic [FP_W-1:0] rsp_sum_reg, rsp_sum_next;
    logic            proto_err_reg, proto_err_next;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;

    logic [FP_W-1:0] lane_a [NREQ];
    logic [FP_W-1:0] lane_b [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_a[gi] = req_a[gi*FP_W +: FP_W];
            assign lane_b[gi] = req_b[gi*FP_W +: FP_W];
        end
    endgenerate

    fpadd_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    // State, operand, tag and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= S_WAIT;
            rr_ptr_reg    <= '0;
            inflight_reg  <= 1'b0;
            opa_reg       <= FP_POS_ZERO;
            opb_reg       <= FP_POS_ZERO;
            cur_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_sum_reg   <= FP_POS_ZERO;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            inflight_reg  <= inflight_next;
            opa_reg       <= opa_next;
            opb_reg       <= opb_next;
            cur_id_reg    <= cur_id_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_sum_reg   <= rsp_sum_next;
            proto_err_reg <= proto_err_next;
        end
    end

    // Next-state, adder operand sequencing, accept and response logic.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        inflight_next  = inflight_reg;
        opa_next       = opa_reg;
        opb_next       = opb_reg;
        cur_id_next    = cur_id_reg;
        rsp_valid_next = 1'b0;
        rsp_id_next    = rsp_id_reg;
        rsp_sum_next   = rsp_sum_reg;
        proto_err_next = proto_err_reg;
        req_ready      = '0;
        fpa_a          = FP_POS_ZERO;

        case (state_reg)
            S_WAIT: begin
                // First ready cycle (R1): retire previous op, accept next one.
                if (fpa_ready) begin
                    if (inflight_reg) begin
                        rsp_valid_next = 1'b1;
                        rsp_id_next    = cur_id_reg;
                        rsp_sum_next   = fpa_sum;
                    end
                    if (gnt_any && !reset) begin
                        req_ready     = gnt_onehot;
                        opa_next      = lane_a[gnt_idx];
                        opb_next      = lane_b[gnt_idx];
                        cur_id_next   = gnt_idx;
                        inflight_next = 1'b1;
                        rr_ptr_next   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    end else begin
                        opa_next      = FP_POS_ZERO;
                        opb_next      = FP_POS_ZERO;
                        inflight_next = 1'b0;
                    end
                    state_next = S_OPA;
                end
            end
            S_OPA: begin
                // Second ready cycle (R2): adder captures operand A.
                fpa_a = inflight_reg ? opa_reg : FP_POS_ZERO;
                if (!fpa_ready) begin
                    proto_err_next = 1'b1;
                    inflight_next  = 1'b0;
                    state_next     = S_WAIT;
                end else begin
                    state_next = S_OPB;
                end
            end
            S_OPB: begin
                // Load cycle for operand B; ready must already be low.
                fpa_a = inflight_reg ? opb_reg : FP_POS_ZERO;
                if (fpa_ready) begin
                    proto_err_next = 1'b1;
                end
                state_next = S_WAIT;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign busy      = inflight_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_fpadd_sched.sv
// Scoreboard bench for fpadd_sched with a behavioural serial adder model.
// Operands are multiples of 0.5 so every sum is exactly representable.
module tb_fpadd_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int P_R1 = 0, P_R2 = 1, P_LB = 2, P_COMP = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_a, req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_sum;
    logic                 fpa_ready;
    logic [31:0]          fpa_sum, fpa_a;
    logic                 busy, proto_err;

    always #5 clock = ~clock;

    fpadd_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .fpa_ready(fpa_ready), .fpa_sum(fpa_sum), .fpa_a(fpa_a),
        .busy(busy), .proto_err(proto_err)
    );

    int errors = 0;
    int checks = 0;

    typedef struct { int id; logic [31:0] sum; } exp_t;
    exp_t sb_q[$];

    // Float encoding of the value n*0.5 (n < 2^23).
    function automatic logic [31:0] enc(input int unsigned n);
        logic [31:0] nv, m;
        int p;
        if (n == 0) return 32'h0;
        nv = n;
        p = 0;
        for (int k = 0; k < 32; k++) if (nv[k]) p = k;
        m = nv << (23 - p);
        return {1'b0, 8'(126 + p), m[22:0]};
    endfunction

    function automatic int unsigned dec(input logic [31:0] f);
        logic [31:0] full;
        int p;
        if (f == 32'h0) return 0;
        p = int'(f[30:23]) - 126;
        full = {9'h1, f[22:0]};
        return full >> (23 - p);
    endfunction

    // ---------------- behavioural serial adder ----------------
    int ph, cnt;
    logic [31:0] cap_a, cap_b, fsum_reg;
    int inject_req = 0;
    int inject_ack;

    assign fpa_ready = (ph == P_R1) || (ph == P_R2 && inject_req == inject_ack);
    assign fpa_sum   = fsum_reg;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ph <= P_R1; cnt <= 0; fsum_reg <= '0; cap_a <= '0; cap_b <= '0;
            inject_ack <= inject_req;
        end else begin
            case (ph)
                P_R1: ph <= P_R2;
                P_R2: begin
                    if (inject_req != inject_ack) begin
                        inject_ack <= inject_req;
                        ph <= P_COMP;
                        cnt <= int'($urandom_range(1, 4));
                    end else begin
                        cap_a <= fpa_a;
                        ph <= P_LB;
                    end
                end
                P_LB: begin
                    cap_b <= fpa_a;
                    ph <= P_COMP;
                    cnt <= int'($urandom_range(1, 5));
                end
                default: begin
                    if (cnt <= 1) begin
                        fsum_reg <= enc(dec(cap_a) + dec(cap_b));
                        ph <= P_R1;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
            endcase
        end
    end

    // ---------------- requester lanes ----------------
    bit lane_valid[NREQ];
    int unsigned lane_na[NREQ], lane_nb[NREQ];
    int model_ptr = 0;
    int last_acc;
    int acc_log[$];
    bit no_push = 0;
    bit rand_mode = 0;

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]      = lane_valid[i];
            req_a[i*32 +: 32] = enc(lane_na[i]);
            req_b[i*32 +: 32] = enc(lane_nb[i]);
        end
    endtask

    task automatic set_lane(input int i, input int unsigned na, input int unsigned nb);
        lane_valid[i] = 1'b1; lane_na[i] = na; lane_nb[i] = nb;
        apply();
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NREQ; i++) lane_valid[i] = 1'b0;
        apply();
    endtask

    function automatic int exp_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (lane_valid[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: check accepts at negedge, then drive new inputs after posedge.
    task automatic step();
        int w;
        logic [NREQ-1:0] ev;
        @(negedge clock);
        last_acc = -1;
        w = exp_winner();
        ev = '0;
        if (ph == P_R1 && w >= 0) ev[w] = 1'b1;
        if (req_ready != '0 || ev != '0) begin
            checks++;
            if (req_ready !== ev) begin
                errors++;
                $display("FAIL accept_winner: req_ready=%b required=%b", req_ready, ev);
            end else begin
                if (!no_push) sb_q.push_back('{id: w, sum: enc(lane_na[w] + lane_nb[w])});
                $display("accept lane=%0d a=%h b=%h", w, enc(lane_na[w]), enc(lane_nb[w]));
                model_ptr = (w + 1) % NREQ;
                lane_valid[w] = 1'b0;
                last_acc = w;
                acc_log.push_back(w);
            end
        end
        @(posedge clock); #1;
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (lane_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) lane_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    lane_valid[i] = 1'b1;
                    lane_na[i] = $urandom_range(0, 4000);
                    lane_nb[i] = $urandom_range(0, 4000);
                end
            end
        end
        apply();
    endtask

    task automatic wait_accept(input int lane, input int maxc);
        int n = 0;
        do begin step(); n++; end while (last_acc != lane && n < maxc);
        checks++;
        if (last_acc != lane) begin
            errors++;
            $display("FAIL accept_timeout: lane=%0d not accepted within %0d cycles", lane, maxc);
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb_q.size() > 0 && n < maxc) begin step(); n++; end
        checks++;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_sum", rsp_sum, 32'h0);
        chk("rst_fpa_a", fpa_a, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_proto_err", 32'(proto_err), 32'h0);
    endtask

    // ---------------- response monitor ----------------
    logic [IDW-1:0] last_rsp_id;
    logic [31:0]    last_rsp_sum;

    initial begin
        bit prev_rsp = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_rsp = 1'b0;
            end else begin
                if (rsp_valid) begin
                    checks++;
                    last_rsp_id  = rsp_id;
                    last_rsp_sum = rsp_sum;
                    if (prev_rsp) begin
                        errors++;
                        $display("FAIL rsp_width: rsp_valid high for 2 cycles, required 1");
                    end else if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: id=%0d sum=%h, required no response", rsp_id, rsp_sum);
                    end else begin
                        e = sb_q.pop_front();
                        if (rsp_id !== IDW'(e.id) || rsp_sum !== e.sum) begin
                            errors++;
                            $display("FAIL rsp_data: id=%0d sum=%h required id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.sum);
                        end else begin
                            $display("response id=%0d sum=%h", rsp_id, rsp_sum);
                        end
                    end
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int saved_ptr;
        int n;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        clear_lanes();
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b0;

        // All requesters continuously valid: strict rotation from pointer 0.
        acc_log.delete();
        for (int i = 0; i < NREQ; i++) set_lane(i, 2 * i + 1, 3);
        n = 0;
        while (acc_log.size() < 5 && n < 300) begin
            step(); n++;
            if (last_acc >= 0) set_lane(last_acc, $urandom_range(0, 500), $urandom_range(0, 500));
        end
        checks++;
        if (acc_log.size() < 5) begin
            errors++;
            $display("FAIL order_timeout: %0d accepts, required 5", acc_log.size());
        end else begin
            for (int i = 0; i < 5; i++) chk("accept_order", 32'(acc_log[i]), 32'(exp_order[i]));
        end
        clear_lanes();
        drain(200);

        // Directed 1.0 + 2.0 on requester 0, with operand sequencing on fpa_a.
        set_lane(0, 2, 4);
        wait_accept(0, 100);
        @(negedge clock);
        chk("fpa_a_R2", fpa_a, 32'h3F800000);
        @(negedge clock);
        chk("fpa_a_LB", fpa_a, 32'h40000000);
        drain(100);
        chk("sum_1p0_2p0", last_rsp_sum, 32'h40400000);
        chk("id_1p0_2p0", 32'(last_rsp_id), 32'h0);

        // Idle rounds: dummy ops only, pointer must not move.
        saved_ptr = model_ptr;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("idle_fpa_a", fpa_a, 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
        end
        for (int i = 0; i < NREQ; i++) set_lane(i, 10, 10);
        n = 0;
        do begin step(); n++; end while (last_acc < 0 && n < 50);
        chk("idle_ptr_kept", 32'(last_acc), 32'(saved_ptr));
        clear_lanes();
        drain(100);

        // Back-to-back on requester 2: response and re-accept share one R1.
        set_lane(2, 3, 1);
        wait_accept(2, 100);
        set_lane(2, 2, 4);
        wait_accept(2, 100);
        @(negedge clock);
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("b2b_rsp_id", 32'(rsp_id), 32'h2);
        chk("b2b_rsp_sum", rsp_sum, 32'h40000000);
        drain(100);
        chk("b2b_second_sum", last_rsp_sum, 32'h40400000);

        // Randomized traffic with withdrawals.
        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        clear_lanes();
        drain(200);

        // Adder drops ready in R2: sticky error, accepted op discarded.
        n = 0;
        while (ph != P_COMP && n < 20) begin step(); n++; end
        set_lane(3, 5, 7);
        no_push = 1'b1;
        inject_req++;
        wait_accept(3, 60);
        no_push = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("inj_proto_err", 32'(proto_err), 32'h1);
        chk("inj_busy", 32'(busy), 32'h0);
        set_lane(1, 10, 20);
        wait_accept(1, 60);
        drain(100);
        chk("inj_resync_sum", last_rsp_sum, enc(30));
        chk("inj_proto_sticky", 32'(proto_err), 32'h1);

        // Reset while an op is in flight.
        set_lane(0, 8, 8);
        no_push = 1'b1;
        wait_accept(0, 60);
        no_push = 1'b0;
        step();
        reset = 1'b1;
        clear_lanes();
        sb_q.delete();
        model_ptr = 0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (20) step();
        set_lane(2, 6, 6);
        wait_accept(2, 60);
        drain(100);
        chk("post_reset_sum", last_rsp_sum, enc(12));
        chk("post_reset_id", 32'(last_rsp_id), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpadd_sched.md
# fpadd_sched

Round-robin scheduler that shares one serial `fpadder` instance between NREQ requesters. Each requester presents a 32-bit operand pair; the scheduler drives the adder's operand-load sequence and returns the tagged sum. A at most one addition is in flight. The block sits between the requester agents and the single adder.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in NREQ: per-requester request.
- `req_a` in NREQ×32: operand A, packed, lane i at `[32i+31:32i]`.
- `req_b` in NREQ×32: operand B, same packing.
- `req_ready` out NREQ: one-hot accept pulse.
- `rsp_valid` out 1: one-cycle result strobe.
- `rsp_id` out IDW: requester that owns the result.
- `rsp_sum` out 32: IEEE-754 single-precision sum.
- `fpa_ready` in 1: adder `ready`.
- `fpa_sum` in 32: adder `sum`.
- `fpa_a` out 32: adder operand port `a`.
- `busy` out 1: a real request is in flight.
- `proto_err` out 1: sticky adder-handshake violation.

## Operation
Adder contract, fixed by the adder design:
- After reset or completion, `fpa_ready` is high for exactly 2 cycles, R1 and R2.
- The adder samples `fpa_a` as operand A at the end of R2.
- It samples operand B at the end of the following cycle, LB, in which `fpa_ready` is low.
- `fpa_sum` is valid and stable from R1 until the next result is written.
- The adder's `nreset` must be tied to `~reset` at integration, so both blocks restart together.

FSM states and transitions:
- **S_WAIT**: wait for `fpa_ready==1`. That cycle is R1.
  - If `inflight==1`, register `fpa_sum` and `cur_id` to the response outputs.
  - Arbitrate. If a winner exists, assert `req_ready[w]` combinationally this cycle, latch `req_a[w]`, `req_b[w]`, `cur_id=w`, and set `inflight=1`. Otherwise set `inflight=0`.
  - Go to S_OPA.
- **S_OPA** (R2): `fpa_a = opA_q`, or 0 for a dummy op.
  - If `fpa_ready==0`, set `proto_err`, clear `inflight`, go to S_WAIT.
  - Otherwise go to S_OPB.
- **S_OPB** (LB): `fpa_a = opB_q`, or 0 for a dummy op.
  - If `fpa_ready==1`, set `proto_err`.
  - Go to S_WAIT.

Dummy ops:
- The adder cycles continuously.
- With no request at R1, it is fed 0+0, and the result is discarded (no `rsp_valid`).

Arbitration:
- Round-robin pointer `rr_ptr`, reset 0.
- The winner is the first asserted `req_valid` searching `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
- On a grant, `rr_ptr = (w+1) mod NREQ`. Without a grant, `rr_ptr` is unchanged.

Requester rules:
- A requester holds `req_valid`, `req_a` and `req_b` stable until its `req_ready` pulse.
- Dropping `req_valid` before acceptance is allowed (withdrawal).
- A requester may re-request in the cycle after its accept.

Other rules:
- `fpa_a` is 0 in S_WAIT.
- `busy` = `inflight`.
- No arithmetic is performed on data; values pass through unmodified.

## Timing
- Reset values:
  - State S_WAIT; `rr_ptr`, `inflight`, `proto_err`, `rsp_valid` = 0.
  - `rsp_id`, `rsp_sum`, `fpa_a` = 0; `req_ready` = 0; `busy` = 0.
- Reset mid-operation: the in-flight request is lost without a response. The requester was already accepted, so it must re-issue at system level.
- `req_ready` is only ever asserted in the R1 cycle. At most one bit is high.
- `rsp_valid`: exactly one cycle, the cycle after the R1 that completes a real op. `rsp_id` and `rsp_sum` hold their value until the next response.
- Accept-to-response latency equals the adder latency (data-dependent: align and normalize loop counts) plus 1 cycle. Minimum turnaround per op is 3 scheduler cycles plus the adder compute time.
- Simultaneous events:
  - At R1, the previous result is returned and a new request is accepted in the same cycle.
  - The response for requester i and a new accept for requester i may coincide.

## Structure
- Package `fpadd_pkg`:
  - `typedef enum logic [1:0] {S_WAIT, S_OPA, S_OPB} fpsched_state_t`
  - `localparam FP_W = 32`
  - `localparam logic [31:0] FP_POS_ZERO = '0`
- Sub-module `fpadd_rr_arb` (parameter NREQ): inputs `req`, `ptr`; outputs `gnt_onehot`, `gnt_idx`, `gnt_any`. Purely combinational. `rr_ptr` lives in the parent.
- Top: FSM, operand/tag registers, response registers, `proto_err` flag.

## Test plan
- Single request, 1.0 + 2.0: requester 0 with `req_a`=0x3F800000, `req_b`=0x40000000 → `fpa_a` shows 0x3F800000 in R2 and 0x40000000 in LB; `rsp_valid` with `rsp_id`=0, `rsp_sum`=0x40400000.
- All 4 requesters valid continuously → accepts in order 0,1,2,3,0; each `rsp_id` matches its accept order; no accept is skipped or duplicated.
- Idle adder, no requests for 3 adder rounds → `fpa_a` stays 0, no `rsp_valid`, `busy`=0; `rr_ptr` unchanged.
- Back-to-back: requester 2 re-requests right after its accept → the new accept lands in the same R1 cycle as the response for the first op; both sums correct (e.g. 1.5+0.5 = 0x40000000).
- Assert `reset` mid-op, after accept and before response → all outputs return to reset values; no stale `rsp_valid` afterwards; the next request completes normally.
- Force `fpa_ready` low in S_OPA via the adder model → `proto_err`=1 and stays 1; `inflight` cleared; the FSM resynchronizes on the next `fpa_ready` high.
